lsu_issue_window: RTL

- Small age-ordered instruction window between ID and the issue stage.
- Holds up to DEPTH decoded instructions and picks one per cycle for issue.
- When the oldest entry is a LOAD/STORE and the LSU is not ready, it issues a younger, independent, non-memory instruction ahead of it.
- A bypass cap bounds how long the memory op can be starved; flush and debug force plain in-order behaviour.

---
 rtl/lsu_issue_window.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lsu_issue_window.sv
// Age-ordered issue window: in-order by default, lets a younger independent ALU op
// overtake a load/store stalled on the LSU, with a cap on consecutive overtakes.
package ariane_pkg;
   typedef enum logic [2:0] {NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR} fu_t;

   typedef struct packed {
      logic [31:0] pc;
      fu_t         fu;
      logic [7:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } scoreboard_entry_t;
endpackage

module lsu_issue_window
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned MAX_BYPASS = 3
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         debug_req_i,
   input  scoreboard_entry_t            issue_entry_i,
   input  logic                         issue_entry_valid_i,
   input  logic                         is_ctrl_flow_i,
   output logic                         issue_instr_ack_o,
   output scoreboard_entry_t            issue_entry_o,
   output logic                         issue_entry_valid_o,
   output logic                         is_ctrl_flow_o,
   input  logic                         issue_instr_ack_i,
   input  logic                         lsu_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         bypass_o
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned BW = 4;

   scoreboard_entry_t sbe_reg  [DEPTH];
   scoreboard_entry_t sbe_next [DEPTH];
   logic [DEPTH-1:0]  cf_reg, cf_next;
   logic [CW-1:0]     count_reg, count_next;
   logic [BW-1:0]     byp_cnt_reg, byp_cnt_next;

   logic [DEPTH-1:0]  valid, barrier, plain_alu, cand;
   logic              bypass_allowed;
   logic [IW-1:0]     sel_idx;
   logic [IW-1:0]     wr_idx;
   logic              deq, enq;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic hazard_free;
      logic older_barrier;

      // Raw register-field compares against every older entry, x0 included.
      always_comb begin
         hazard_free   = 1'b1;
         older_barrier = 1'b0;
         for (int j = 0; j < gi; j++) begin
            if (barrier[j])
               older_barrier = 1'b1;
            if (sbe_reg[gi].rs1 == sbe_reg[j].rd  ||
                sbe_reg[gi].rs2 == sbe_reg[j].rd  ||
                sbe_reg[gi].rd  == sbe_reg[j].rs1 ||
                sbe_reg[gi].rd  == sbe_reg[j].rs2 ||
                sbe_reg[gi].rd  == sbe_reg[j].rd)
               hazard_free = 1'b0;
         end
      end

      assign valid[gi]     = count_reg > CW'(gi);
      assign barrier[gi]   = (sbe_reg[gi].fu == CTRL_FLOW) || cf_reg[gi];
      assign plain_alu[gi] = !(sbe_reg[gi].fu inside {LOAD, STORE, CTRL_FLOW}) && !cf_reg[gi];
      assign cand[gi]      = (gi != 0) && valid[gi] && plain_alu[gi] && hazard_free && !older_barrier;
   end

   assign bypass_allowed = valid[0] && (sbe_reg[0].fu inside {LOAD, STORE}) && !lsu_ready_i &&
                           !debug_req_i && (byp_cnt_reg < BW'(MAX_BYPASS));

   // Scan downward so the lowest eligible candidate is the one left standing.
   always_comb begin
      sel_idx = '0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (bypass_allowed && cand[k])
            sel_idx = IW'(k);
      end
   end

   assign issue_entry_valid_o = valid[0];
   assign issue_entry_o       = valid[0] ? sbe_reg[sel_idx] : '0;
   assign is_ctrl_flow_o      = valid[0] ? cf_reg[sel_idx] : 1'b0;
   assign issue_instr_ack_o   = count_reg < CW'(DEPTH);
   assign count_o             = count_reg;

   assign deq      = valid[0] && issue_instr_ack_i;
   assign enq      = issue_entry_valid_i && issue_instr_ack_o;
   assign bypass_o = deq && (sel_idx != '0);
   assign wr_idx   = IW'(count_reg - CW'(deq));

   always_comb begin
      sbe_next     = sbe_reg;
      cf_next      = cf_reg;
      count_next   = count_reg;
      byp_cnt_next = byp_cnt_reg;

      if (deq) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (i >= int'(sel_idx)) begin
               sbe_next[i] = sbe_reg[i+1];
               cf_next[i]  = cf_reg[i+1];
            end
         end
         sbe_next[DEPTH-1] = '0;
         cf_next[DEPTH-1]  = 1'b0;
      end

      // Write lands after compaction so the new entry stays youngest.
      if (enq) begin
         sbe_next[wr_idx] = issue_entry_i;
         cf_next[wr_idx]  = is_ctrl_flow_i;
      end
      count_next = count_reg + CW'(enq) - CW'(deq);

      if (debug_req_i || (deq && sel_idx == '0))
         byp_cnt_next = '0;
      else if (bypass_o && byp_cnt_reg < BW'(MAX_BYPASS))
         byp_cnt_next = byp_cnt_reg + 1'b1;

      if (flush_i) begin
         for (int i = 0; i < DEPTH; i++)
            sbe_next[i] = '0;
         cf_next      = '0;
         count_next   = '0;
         byp_cnt_next = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++)
            sbe_reg[i] <= '0;
         cf_reg      <= '0;
         count_reg   <= '0;
         byp_cnt_reg <= '0;
      end else begin
         sbe_reg     <= sbe_next;
         cf_reg      <= cf_next;
         count_reg   <= count_next;
         byp_cnt_reg <= byp_cnt_next;
      end
   end
endmodule
